// File: rtl/zap_shift_fwd_stage_pkg.sv
// Shared definitions for the shift/forward stage: shift op codes,
// condition-code constants and the output skid-buffer states.
package zap_shift_fwd_stage_pkg;

    localparam int SHIFT_OPS = 5;
    localparam int SW        = $clog2(SHIFT_OPS);

    typedef enum logic [SW-1:0] {
        SH_LSL,
        SH_LSR,
        SH_ASR,
        SH_ROR,
        SH_RORI
    } shift_op_t;

    // Condition field sits in the low nibble of the control bundle.
    localparam logic [3:0] COND_NV  = 4'b1111;
    localparam int         COND_LSB = 0;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL1,
        ST_FULL2
    } skid_state_t;

endpackage

// File: rtl/zap_shift_fwd_stage_if.sv
// Issue/bypass/ALU-facing signal bundle of the shift/forward stage.
// master = issue/bypass/ALU environment, slave = the stage itself.
interface zap_shift_fwd_stage_if #(
    parameter int PHY_REGS = 46,
    parameter int DW       = 32,
    parameter int NUM_OPS  = 3,
    parameter int NUM_FWD  = 3,
    parameter int CTRL_W   = 64
);
    import zap_shift_fwd_stage_pkg::*;

    localparam int IW = $clog2(PHY_REGS);

    logic                        i_clear_hi;
    logic                        i_clear_lo;
    logic                        i_valid;
    logic                        o_ready;
    logic [NUM_OPS*(DW+1)-1:0]   i_src_idx;
    logic [NUM_OPS*DW-1:0]       i_src_val;
    logic [SW-1:0]               i_shift_type;
    logic [7:0]                  i_shift_amt;
    logic                        i_disable_sh;
    logic                        i_carry_in;
    logic [IW-1:0]               i_dest_idx;
    logic [CTRL_W-1:0]           i_ctrl;
    logic [NUM_FWD-1:0]          i_fwd_valid;
    logic [NUM_FWD-1:0]          i_fwd_pending;
    logic [NUM_FWD*IW-1:0]       i_fwd_idx;
    logic [NUM_FWD*DW-1:0]       i_fwd_val;
    logic                        o_valid;
    logic                        i_ready;
    logic [NUM_OPS*DW-1:0]       o_ops;
    logic                        o_shift_carry;
    logic                        o_rrx;
    logic [IW-1:0]               o_dest_idx;
    logic [CTRL_W-1:0]           o_ctrl;
    logic                        o_hazard;
    logic [15:0]                 o_hazard_cnt;

    modport master (
        output i_clear_hi, i_clear_lo, i_valid, i_src_idx, i_src_val, i_shift_type,
               i_shift_amt, i_disable_sh, i_carry_in, i_dest_idx, i_ctrl,
               i_fwd_valid, i_fwd_pending, i_fwd_idx, i_fwd_val, i_ready,
        input  o_ready, o_valid, o_ops, o_shift_carry, o_rrx, o_dest_idx, o_ctrl,
               o_hazard, o_hazard_cnt
    );

    modport slave (
        input  i_clear_hi, i_clear_lo, i_valid, i_src_idx, i_src_val, i_shift_type,
               i_shift_amt, i_disable_sh, i_carry_in, i_dest_idx, i_ctrl,
               i_fwd_valid, i_fwd_pending, i_fwd_idx, i_fwd_val, i_ready,
        output o_ready, o_valid, o_ops, o_shift_carry, o_rrx, o_dest_idx, o_ctrl,
               o_hazard, o_hazard_cnt
    );

endinterface

// File: rtl/zap_shift_fwd_stage_barrel.sv
// Combinational ARM-style barrel shifter: LSL/LSR/ASR/ROR with carry-out,
// and RRX when an immediate rotate (RORI) has a zero amount.
module zap_shift_barrel
    import zap_shift_fwd_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] src,
    input  logic [7:0]    amt,
    input  logic [SW-1:0] shift_type,
    input  logic          cin,
    output logic [DW-1:0] res,
    output logic          carry,
    output logic          rrx
);

    localparam int RW = $clog2(DW);

    int                   a;
    logic [RW-1:0]        rot;
    logic [DW-1:0]        lsl_tap;
    logic [DW-1:0]        lsr_tap;
    logic [DW-1:0]        ror_res;
    logic signed [DW-1:0] src_s;

    // Select result and carry-out for the requested shift op and amount.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        res     = src;
        carry   = cin;
        rrx     = 1'b0;
        a       = int'(amt);
        rot     = amt[RW-1:0];
        src_s   = src;
        // Carry taps: last bit shifted out for a left/right shift by a.
        lsl_tap = src >> (DW - a);
        lsr_tap = src >> (a - 1);
        ror_res = (src >> rot) | (src << (DW - int'(rot)));

        case (shift_type)
            SH_LSL: begin
                if (a != 0 && a < DW) begin
                    res   = src << amt;
                    carry = lsl_tap[0];
                end else if (a == DW) begin
                    res   = '0;
                    carry = src[0];
                end else if (a > DW) begin
                    res   = '0;
                    carry = 1'b0;
                end
            end
            SH_LSR: begin
                if (a != 0 && a < DW) begin
                    res   = src >> amt;
                    carry = lsr_tap[0];
                end else if (a == DW) begin
                    res   = '0;
                    carry = src[DW-1];
                end else if (a > DW) begin
                    res   = '0;
                    carry = 1'b0;
                end
            end
            SH_ASR: begin
                if (a != 0 && a < DW) begin
                    res   = src_s >>> amt;
                    carry = lsr_tap[0];
                end else if (a >= DW) begin
                    res   = {DW{src[DW-1]}};
                    carry = src[DW-1];
                end
            end
            SH_ROR, SH_RORI: begin
                if (a == 0) begin
                    if (shift_type == SH_RORI) begin
                        res   = {cin, src[DW-1:1]};
                        carry = src[0];
                        rrx   = 1'b1;
                    end
                end else begin
                    res   = ror_res;
                    carry = ror_res[DW-1];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/zap_shift_fwd_stage.sv
// Shift/operand-resolve stage between issue and ALU: resolves operands
// against prioritised bypass sources, interlocks on pending loads, shifts
// operand 1 and hands the result to the ALU through a two-entry skid buffer.
module zap_shift_fwd_stage
    import zap_shift_fwd_stage_pkg::*;
#(
    parameter int PHY_REGS = 46,
    parameter int DW       = 32,
    parameter int NUM_OPS  = 3,
    parameter int NUM_FWD  = 3,
    parameter int CTRL_W   = 64
) (
    input logic                 i_clk,
    input logic                 i_reset_n,
    zap_shift_fwd_stage_if.slave bus
);

    localparam int IW = $clog2(PHY_REGS);
    // Payload layout, MSB to LSB: {ops, carry, rrx, dest, ctrl}.
    localparam int PW = NUM_OPS*DW + 2 + IW + CTRL_W;
    localparam logic [PW-1:0] PAYLOAD_RST = PW'(COND_NV) << COND_LSB;

    // Returns {stall, value}. Lowest-numbered matching bypass wins; an
    // immediate operand never looks at the bypass network.
    function automatic logic [DW:0] resolve(
        input logic [DW:0]           idx,
        input logic [DW-1:0]         reg_val,
        input logic [NUM_FWD-1:0]    fwd_valid,
        input logic [NUM_FWD-1:0]    fwd_pending,
        input logic [NUM_FWD*IW-1:0] fwd_idx,
        input logic [NUM_FWD*DW-1:0] fwd_val
    );
        logic [DW-1:0] val;
        logic          stall;
        val   = reg_val;
        stall = 1'b0;
        if (idx[DW]) begin
            val = idx[DW-1:0];
        end else begin
            for (int k = NUM_FWD-1; k >= 0; k--) begin
                if (fwd_valid[k] && fwd_idx[k*IW +: IW] == idx[IW-1:0]) begin
                    val   = fwd_val[k*DW +: DW];
                    stall = fwd_pending[k];
                end
            end
        end
        return {stall, val};
    endfunction

    logic [NUM_OPS*DW-1:0] res_ops;
    logic [NUM_OPS-1:0]    op_stall;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_resolve
        logic [DW:0] r;
        assign r = resolve(bus.i_src_idx[g*(DW+1) +: DW+1], bus.i_src_val[g*DW +: DW],
                           bus.i_fwd_valid, bus.i_fwd_pending, bus.i_fwd_idx, bus.i_fwd_val);
        assign res_ops[g*DW +: DW] = r[DW-1:0];
        assign op_stall[g]         = r[DW];
    end

    logic [DW-1:0] bar_res;
    logic          bar_carry;
    logic          bar_rrx;

    zap_shift_barrel #(.DW(DW)) u_barrel (
        .src        (res_ops[DW +: DW]),
        .amt        (bus.i_shift_amt),
        .shift_type (bus.i_shift_type),
        .cin        (bus.i_carry_in),
        .res        (bar_res),
        .carry      (bar_carry),
        .rrx        (bar_rrx)
    );

    logic [NUM_OPS*DW-1:0] ops_next;
    logic                  sh_carry;
    logic                  sh_rrx;

    // Operand 1 slot carries the shifter output unless shifting is bypassed.
    always_comb begin
        ops_next = res_ops;
        sh_carry = bar_carry;
        sh_rrx   = bar_rrx;
        ops_next[DW +: DW] = bar_res;
        if (bus.i_disable_sh) begin
            ops_next[DW +: DW] = res_ops[DW +: DW];
            sh_carry           = bus.i_carry_in;
            sh_rrx             = 1'b0;
        end
    end

    skid_state_t   state;
    logic [PW-1:0] out_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] payload_in;
    logic          hazard;
    logic          accept;
    logic          take;
    logic          held;
    logic          flush;
    logic [15:0]   hazard_cnt;

    assign payload_in = {ops_next, sh_carry, sh_rrx, bus.i_dest_idx, bus.i_ctrl};
    assign hazard     = bus.i_valid && (|op_stall);
    assign bus.o_ready = i_reset_n && (state != ST_FULL2) && !hazard;
    assign accept     = bus.i_valid && bus.o_ready;
    assign take       = (state != ST_EMPTY) && bus.i_ready;
    assign held       = (state != ST_EMPTY) && !bus.i_ready;
    // A low-priority flush must not yank data the ALU has not yet taken.
    assign flush      = bus.i_clear_hi || (bus.i_clear_lo && !held);

    // Skid-buffer FSM and registered output payload.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_reset_n) begin
            state <= ST_EMPTY;
            out_q <= PAYLOAD_RST;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q <= payload_in;
                        state <= ST_FULL1;
                    end
                end
                ST_FULL1: begin
                    if (accept && take) begin
                        out_q <= payload_in;
                    end else if (accept) begin
                        state <= ST_FULL2;
                    end else if (take) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL2: begin
                    if (take) begin
                        out_q <= skid_q;
                        state <= ST_FULL1;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Second entry: captures an accept the stalled ALU could not take.
    always_ff @(posedge i_clk) begin
        // NOTE: skid data is not reset; it is only observed after being
        // written, and the state register alone says whether it is live.
        if (state == ST_FULL1 && accept && !take && !flush) begin
            skid_q <= payload_in;
        end
    end

    // Saturating count of interlock cycles; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hazard_cnt <= '0;
        end else if (hazard && hazard_cnt != 16'hFFFF) begin
            hazard_cnt <= hazard_cnt + 16'd1;
        end
    end

    assign bus.o_valid       = (state != ST_EMPTY);
    assign bus.o_ctrl        = out_q[0 +: CTRL_W];
    assign bus.o_dest_idx    = out_q[CTRL_W +: IW];
    assign bus.o_rrx         = out_q[CTRL_W + IW];
    assign bus.o_shift_carry = out_q[CTRL_W + IW + 1];
    assign bus.o_ops         = out_q[CTRL_W + IW + 2 +: NUM_OPS*DW];
    assign bus.o_hazard      = hazard;
    assign bus.o_hazard_cnt  = hazard_cnt;

endmodule
